// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared 640x480 raster timing constants (common to the timing generator
//   and the receiver), derived periods and visible-window bounds, the
//   receiver lock FSM encoding and a saturating counter helper.
package vga_timing_pkg;

  // Horizontal timing, in pixel clocks.
  localparam int   VGA_H_PIXELS      = 640;
  localparam int   VGA_H_FRONT_PORCH = 16;
  localparam int   VGA_H_SYNC_PULSE  = 96;
  localparam int   VGA_H_BACK_PORCH  = 48;
  localparam logic VGA_H_POL         = 1'b0;

  // Vertical timing, in lines.
  localparam int   VGA_V_PIXELS      = 480;
  localparam int   VGA_V_FRONT_PORCH = 10;
  localparam int   VGA_V_SYNC_PULSE  = 2;
  localparam int   VGA_V_BACK_PORCH  = 33;
  localparam logic VGA_V_POL         = 1'b0;

  localparam int VGA_H_PERIOD = VGA_H_PIXELS + VGA_H_FRONT_PORCH
                              + VGA_H_SYNC_PULSE + VGA_H_BACK_PORCH;   // 800
  localparam int VGA_V_PERIOD = VGA_V_PIXELS + VGA_V_FRONT_PORCH
                              + VGA_V_SYNC_PULSE + VGA_V_BACK_PORCH;   // 525

  // Positions are counted from the sync leading edge, so the visible
  // window starts after sync + back porch.
  localparam int VGA_H_VIS_START = VGA_H_SYNC_PULSE + VGA_H_BACK_PORCH;  // 144
  localparam int VGA_H_VIS_END   = VGA_H_VIS_START + VGA_H_PIXELS - 1;   // 783
  localparam int VGA_V_VIS_START = VGA_V_SYNC_PULSE + VGA_V_BACK_PORCH;  // 35
  localparam int VGA_V_VIS_END   = VGA_V_VIS_START + VGA_V_PIXELS - 1;   // 514

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/vga_timing_receiver_sync_edge_detect.sv
// sync_edge_detect
//   Registers one sync input, normalises it to active-high and flags the
//   first cycle of each active period.
//   clk, reset : pixel clock, async active-high reset
//   sync_i     : raw sync pin
//   edge_o     : one-cycle pulse on the inactive->active transition
module sync_edge_detect #(
  parameter logic POL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_i,
  output logic edge_o
);

  logic act_q;
  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      act_q  <= sync_i ^ ~POL;
      prev_q <= act_q;
    end
  end

  // A sync held active creates no further edges.
  assign edge_o = act_q & ~prev_q;

endmodule

// File: rtl/vga_timing_receiver.sv
// vga_timing_receiver
//   Sink side of the VGA raster timing. Recovers pixel coordinates and a
//   display-enable strobe from h_sync/v_sync, measures line and frame
//   lengths and locks after LOCK_FRAMES consecutive conforming frames.
//   clk, reset       : pixel clock, async active-high reset
//   h_sync, v_sync   : sync pins from the timing source
//   display_enable   : visible pixel while locked
//   row, column      : recovered visible coordinates (hold outside window)
//   locked           : lock status
//   timing_error     : one-cycle pulse on nonconformance in VERIFY/LOCKED
//   h_period_meas    : length of the last completed line, in clocks
//   v_lines_meas     : lines in the last completed frame
//   All outputs lag the sync pins by two clocks.
module vga_timing_receiver
  import vga_timing_pkg::*;
#(
  parameter int   H_PIXELS      = VGA_H_PIXELS,
  parameter int   H_FRONT_PORCH = VGA_H_FRONT_PORCH,
  parameter int   H_SYNC_PULSE  = VGA_H_SYNC_PULSE,
  parameter int   H_BACK_PORCH  = VGA_H_BACK_PORCH,
  parameter logic H_POL         = VGA_H_POL,
  parameter int   V_PIXELS      = VGA_V_PIXELS,
  parameter int   V_FRONT_PORCH = VGA_V_FRONT_PORCH,
  parameter int   V_SYNC_PULSE  = VGA_V_SYNC_PULSE,
  parameter int   V_BACK_PORCH  = VGA_V_BACK_PORCH,
  parameter logic V_POL         = VGA_V_POL,
  parameter int   H_TOL         = 0,
  parameter int   LOCK_FRAMES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        h_sync,
  input  logic        v_sync,
  output logic        display_enable,
  output logic [15:0] row,
  output logic [15:0] column,
  output logic        locked,
  output logic        timing_error,
  output logic [15:0] h_period_meas,
  output logic [15:0] v_lines_meas
);

  localparam int H_PERIOD = H_PIXELS + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
  localparam int V_PERIOD = V_PIXELS + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
  localparam logic [15:0] H_START = 16'(H_SYNC_PULSE + H_BACK_PORCH);
  localparam logic [15:0] H_END   = 16'(H_SYNC_PULSE + H_BACK_PORCH + H_PIXELS - 1);
  localparam logic [15:0] V_START = 16'(V_SYNC_PULSE + V_BACK_PORCH);
  localparam logic [15:0] V_END   = 16'(V_SYNC_PULSE + V_BACK_PORCH + V_PIXELS - 1);
  localparam logic [15:0] H_WD    = 16'(2 * H_PERIOD);
  localparam logic [15:0] V_LINES = 16'(V_PERIOD);

  logic hs_edge, vs_edge;

  sync_edge_detect #(.POL(H_POL)) u_hs (
    .clk(clk), .reset(reset), .sync_i(h_sync), .edge_o(hs_edge)
  );
  sync_edge_detect #(.POL(V_POL)) u_vs (
    .clk(clk), .reset(reset), .sync_i(v_sync), .edge_o(vs_edge)
  );

  rx_state_e   state_q, state_d;
  logic [15:0] hpos_q, hpos_d;
  logic [15:0] vpos_q, vpos_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic [7:0]  good_q, good_d;
  logic        pend_v_q, pend_v_d;
  logic        first_h_q, first_h_d;
  logic        frame_bad_q, frame_bad_d;
  logic [15:0] row_q, row_d, col_q, col_d;
  logic        de_q, de_d, locked_q, locked_d, err_q, err_d;
  logic [15:0] hper_q, hper_d, vlin_q, vlin_d;

  logic [15:0] h_meas;
  logic        v_apply, line_ok, line_bad, watchdog, in_h, in_v;

  always_comb begin
    // Position counters; hpos is 0 in the edge cycle itself.
    hpos_d  = hs_edge ? 16'd0 : sat_inc(hpos_q);
    h_meas  = sat_inc(hpos_q);
    // A pending (or coincident) v edge takes effect at the next h edge.
    v_apply = hs_edge & (pend_v_q | vs_edge);
    pend_v_d = v_apply ? 1'b0 : (pend_v_q | vs_edge);

    vpos_d     = vpos_q;
    line_cnt_d = line_cnt_q;
    if (v_apply) begin
      vpos_d     = 16'd0;
      line_cnt_d = 16'd1;
    end else if (hs_edge) begin
      vpos_d     = sat_inc(vpos_q);
      line_cnt_d = sat_inc(line_cnt_q);
    end
    hper_d = hs_edge ? h_meas : hper_q;
    vlin_d = v_apply ? line_cnt_q : vlin_q;

    // The first line after reset/SEARCH entry is of unknown length.
    line_ok  = (int'(h_meas) >= H_PERIOD - H_TOL) && (int'(h_meas) <= H_PERIOD + H_TOL);
    line_bad = hs_edge & ~first_h_q & (state_q != SEARCH) & ~line_ok;
    watchdog = ~hs_edge & (hpos_d == H_WD);
    frame_bad_d = v_apply ? 1'b0 : (frame_bad_q | line_bad);
    first_h_d   = hs_edge ? 1'b0 : first_h_q;

    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (v_apply) begin
          state_d = VERIFY;
          good_d  = 8'd0;
        end
      end
      VERIFY: begin
        if (watchdog) begin
          err_d   = 1'b1;
          good_d  = 8'd0;
          state_d = SEARCH;
        end else if (line_bad) begin
          err_d  = 1'b1;
          good_d = 8'd0;
        end else if (v_apply) begin
          // A bad line in this frame was already reported when it ended.
          if (frame_bad_q) begin
            good_d = 8'd0;
          end else if (line_cnt_q != V_LINES) begin
            err_d  = 1'b1;
            good_d = 8'd0;
          end else if (int'(good_q) + 1 >= LOCK_FRAMES) begin
            good_d  = 8'd0;
            state_d = LOCKED;
          end else begin
            good_d = good_q + 8'd1;
          end
        end
      end
      LOCKED: begin
        if (watchdog || line_bad || (v_apply && line_cnt_q != V_LINES)) begin
          err_d   = 1'b1;
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
    if (state_d == SEARCH && state_q != SEARCH) first_h_d = 1'b1;

    locked_d = (state_d == LOCKED);
    in_h  = (hpos_d >= H_START) && (hpos_d <= H_END);
    in_v  = (vpos_d >= V_START) && (vpos_d <= V_END);
    col_d = in_h ? hpos_d - H_START : col_q;
    row_d = in_v ? vpos_d - V_START : row_q;
    de_d  = in_h & in_v & locked_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SEARCH;
      hpos_q      <= '0;
      vpos_q      <= '0;
      line_cnt_q  <= '0;
      good_q      <= '0;
      pend_v_q    <= 1'b0;
      first_h_q   <= 1'b1;
      frame_bad_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      de_q        <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      hper_q      <= '0;
      vlin_q      <= '0;
    end else begin
      state_q     <= state_d;
      hpos_q      <= hpos_d;
      vpos_q      <= vpos_d;
      line_cnt_q  <= line_cnt_d;
      good_q      <= good_d;
      pend_v_q    <= pend_v_d;
      first_h_q   <= first_h_d;
      frame_bad_q <= frame_bad_d;
      row_q       <= row_d;
      col_q       <= col_d;
      de_q        <= de_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      hper_q      <= hper_d;
      vlin_q      <= vlin_d;
    end
  end

  assign display_enable = de_q;
  assign row            = row_q;
  assign column         = col_q;
  assign locked         = locked_q;
  assign timing_error   = err_q;
  assign h_period_meas  = hper_q;
  assign v_lines_meas   = vlin_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Directed bench for vga_timing_receiver on a reduced raster
// (15 clocks x 9 lines) so several frames fit in a short run.
// Instance a uses H_TOL=0, instance b H_TOL=1; both see the same syncs.
module tb_vga_timing_receiver;

  localparam int HPIX = 8, HFP = 2, HSP = 3, HBP = 2, HP = 15;
  localparam int VPIX = 4, VFP = 1, VSP = 2, VBP = 2, VP = 9;
  localparam int HST = 5, VST = 4;

  logic clk = 1'b0, reset = 1'b1, h_sync = 1'b1, v_sync = 1'b1;
  logic        de_a, lock_a, err_a, de_b, lock_b, err_b;
  logic [15:0] row_a, col_a, hper_a, vlin_a, row_b, col_b, hper_b, vlin_b;

  always #5 clk = ~clk;

  vga_timing_receiver #(
    .H_PIXELS(HPIX), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_BACK_PORCH(HBP), .H_POL(1'b0),
    .V_PIXELS(VPIX), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VBP), .V_POL(1'b0),
    .H_TOL(0), .LOCK_FRAMES(2)
  ) dut_a (
    .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
    .display_enable(de_a), .row(row_a), .column(col_a), .locked(lock_a),
    .timing_error(err_a), .h_period_meas(hper_a), .v_lines_meas(vlin_a)
  );

  vga_timing_receiver #(
    .H_PIXELS(HPIX), .H_FRONT_PORCH(HFP), .H_SYNC_PULSE(HSP), .H_BACK_PORCH(HBP), .H_POL(1'b0),
    .V_PIXELS(VPIX), .V_FRONT_PORCH(VFP), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VBP), .V_POL(1'b0),
    .H_TOL(1), .LOCK_FRAMES(2)
  ) dut_b (
    .clk(clk), .reset(reset), .h_sync(h_sync), .v_sync(v_sync),
    .display_enable(de_b), .row(row_b), .column(col_b), .locked(lock_b),
    .timing_error(err_b), .h_period_meas(hper_b), .v_lines_meas(vlin_b)
  );

  int nclk = 0, nchk = 0, npass = 0;
  int de_cnt = 0, err_a_cnt = 0, err_b_cnt = 0, err_clk = -1;
  int first_de = -1, first_row = -1, first_col = -1, last_row = -1, last_col = -1;
  int lock_rise = -1, lock_fall = -1, mark = -1, fstart = -1, lstart = -1;
  bit seen_de = 1'b0;
  logic lock_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Sample outputs at the falling edge, then drive the pins for this clock.
  task automatic tick(input logic hs, input logic vs);
    @(negedge clk);
    nclk++;
    if (de_a === 1'b1) begin
      de_cnt++;
      if (!seen_de) begin
        seen_de = 1'b1; first_de = nclk; first_row = int'(row_a); first_col = int'(col_a);
      end
      last_row = int'(row_a); last_col = int'(col_a);
    end
    if (err_a === 1'b1) begin err_a_cnt++; err_clk = nclk; end
    if (err_b === 1'b1) err_b_cnt++;
    if (lock_a === 1'b1 && lock_prev !== 1'b1) lock_rise = nclk;
    if (lock_a !== 1'b1 && lock_prev === 1'b1) lock_fall = nclk;
    lock_prev = lock_a;
    h_sync = hs;
    v_sync = vs;
  endtask

  task automatic run_line(input int len, input bit vact, input bit mk);
    for (int x = 0; x < len; x++) begin
      tick((x < HSP) ? 1'b0 : 1'b1, vact ? 1'b0 : 1'b1);
      if (x == 0) lstart = nclk;
      if (mk && x == HST) mark = nclk;
    end
  endtask

  task automatic run_lines(input int y0, input int y1, input int long_y, input int long_len);
    for (int y = y0; y < y1; y++) begin
      run_line((y == long_y) ? long_len : HP, y < VSP, y == VST);
      if (y == 0) fstart = lstart;
    end
  endtask

  int de0, e0, eb0, f3, l3, f7, l8, fc, fd, fg, fj;

  initial begin
    repeat (3) tick(1'b1, 1'b1);
    check("rst_locked", {31'd0, lock_a}, 32'd0);
    check("rst_de", {31'd0, de_a}, 32'd0);
    check("rst_row", {16'd0, row_a}, 32'd0);
    check("rst_col", {16'd0, col_a}, 32'd0);
    check("rst_err", {31'd0, err_a}, 32'd0);
    check("rst_hper", {16'd0, hper_a}, 32'd0);
    check("rst_vlin", {16'd0, vlin_a}, 32'd0);
    reset = 1'b0;
    repeat (5) tick(1'b1, 1'b1);

    // Ideal stream: lock at the third v-aligned h edge.
    run_lines(0, VP, -1, 0);
    run_lines(0, VP, -1, 0);
    de0 = de_cnt; seen_de = 1'b0;
    run_lines(0, VP, -1, 0);
    f3 = fstart;
    check("lock_rise", lock_rise, f3 + 2);
    check("de_count", de_cnt - de0, VPIX * HPIX);
    check("de_first_lag", first_de, mark + 2);
    check("de_first_row", first_row, 0);
    check("de_first_col", first_col, 0);
    check("de_last_row", last_row, VPIX - 1);
    check("de_last_col", last_col, HPIX - 1);
    check("hper_ideal", {16'd0, hper_a}, HP);
    check("vlin_ideal", {16'd0, vlin_a}, VP);
    check("no_err_ideal", err_a_cnt + err_b_cnt, 0);

    // One line one clock long while locked.
    e0 = err_a_cnt; eb0 = err_b_cnt;
    run_lines(0, 3, 2, HP + 1);
    run_lines(3, 4, -1, 0);
    l3 = lstart;
    run_lines(4, VP, -1, 0);
    check("long_err_clk", err_clk, l3 + 2);
    check("long_lock_fall", lock_fall, l3 + 2);
    check("long_tol1_noerr", err_b_cnt - eb0, 0);
    check("long_tol1_locked", {31'd0, lock_b}, 32'd1);
    run_lines(0, VP, -1, 0);
    run_lines(0, VP, -1, 0);
    run_lines(0, VP, -1, 0);
    f7 = fstart;
    check("long_relock", lock_rise, f7 + 2);
    check("long_single_err", err_a_cnt - e0, 1);

    // h_sync stuck inactive while locked.
    e0 = err_a_cnt;
    run_lines(0, 1, -1, 0);
    l8 = lstart;
    repeat (40) tick(1'b1, 1'b1);
    check("wd_err_count", err_a_cnt - e0, 1);
    check("wd_err_clk", err_clk, l8 + 2 + 2 * HP);
    check("wd_lock_fall", lock_fall, err_clk);
    check("wd_locked", {31'd0, lock_a}, 32'd0);
    check("wd_de", {31'd0, de_a}, 32'd0);

    // Relock, then a frame one line short.
    run_lines(0, VP, -1, 0);
    run_lines(0, VP, -1, 0);
    run_lines(0, VP - 1, -1, 0);
    fc = fstart;
    check("short_pre_lock", lock_rise, fc + 2);
    e0 = err_a_cnt;
    run_lines(0, 1, -1, 0);
    fd = fstart;
    check("short_vlin", {16'd0, vlin_a}, VP - 1);
    check("short_err_count", err_a_cnt - e0, 1);
    check("short_err_clk", err_clk, fd + 2);
    check("short_lock_fall", lock_fall, fd + 2);
    run_lines(1, VP, -1, 0);

    // Asynchronous reset mid-frame while locked.
    run_lines(0, VP, -1, 0);
    run_lines(0, VP, -1, 0);
    run_lines(0, 1, -1, 0);
    fg = fstart;
    check("pre_rst_locked", {31'd0, lock_a}, 32'd1);
    run_lines(1, 5, -1, 0);
    #2 reset = 1'b1;
    #1;
    check("arst_locked", {31'd0, lock_a}, 32'd0);
    check("arst_de", {31'd0, de_a}, 32'd0);
    check("arst_row", {16'd0, row_a}, 32'd0);
    check("arst_col", {16'd0, col_a}, 32'd0);
    check("arst_hper", {16'd0, hper_a}, 32'd0);
    check("arst_vlin", {16'd0, vlin_a}, 32'd0);
    tick(h_sync, v_sync);
    reset = 1'b0;
    run_lines(5, VP, -1, 0);
    run_lines(0, VP, -1, 0);
    run_lines(0, VP, -1, 0);
    run_lines(0, VP, -1, 0);
    fj = fstart;
    check("arst_relock", lock_rise, fj + 2);
    check("arst_locked_end", {31'd0, lock_a}, 32'd1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/vga_timing_receiver.md
Name: vga_timing_receiver

Overview:
- Sink end of the team's 640x480 VGA raster timing. Samples h_sync/v_sync from a timing source, running on the same pixel clock.
- Recovers pixel coordinates and a display-enable strobe, and measures line and frame lengths.
- Declares lock after consecutive conforming frames. Used as the timing front end of the capture/overlay path and as a self-checking monitor on the timing generator.

Parameters:
- H_PIXELS, 640, visible pixels per line
- H_FRONT_PORCH, 16, clocks from last visible pixel to sync assertion
- H_SYNC_PULSE, 96, h_sync active width in clocks
- H_BACK_PORCH, 48, clocks from sync deassertion to first visible pixel
- H_POL, 0, active level of h_sync
- V_PIXELS, 480; V_FRONT_PORCH, 10; V_SYNC_PULSE, 2; V_BACK_PORCH, 33; V_POL, 0: vertical equivalents, in lines
- H_TOL, 0, allowed +/- deviation of measured line length, in clocks
- LOCK_FRAMES, 2, consecutive good frames required to lock
- H_PERIOD and V_PERIOD are derived as the sums of their four components (800, 525).

Ports:
- clk, input, 1, pixel clock
- reset, input, 1, asynchronous, active-high
- h_sync, input, 1, horizontal sync from source
- v_sync, input, 1, vertical sync from source
- display_enable, output, 1, recovered pixel is visible and receiver is locked
- row, output, 16, recovered visible row, 0..V_PIXELS-1
- column, output, 16, recovered visible column, 0..H_PIXELS-1
- locked, output, 1, timing lock status
- timing_error, output, 1, one-cycle pulse on any nonconformance while VERIFY or LOCKED
- h_period_meas, output, 16, length of last completed line, in clocks
- v_lines_meas, output, 16, lines in last completed frame

Behaviour:
- Reset (async, active-high): all outputs 0, all internal counters 0, FSM in SEARCH.
- Input stage: h_sync and v_sync are registered once and XORed with ~POL, giving active-high hs_a/vs_a. A sync edge is the cycle where the registered active level is 1 and its previous sample is 0.
- hpos (16 bit, saturating at 0xFFFF): 0 on an h edge cycle, otherwise +1.
- Line measurement: on each h edge, h_period_meas <= hpos_prev+1. The first h edge after reset or SEARCH entry is not checked.
- Vertical edge handling: a v edge sets pend_v. At the next h edge, vpos <= 0, v_lines_meas <= line_cnt, line_cnt <= 1, and pend_v is cleared. If a v edge and an h edge coincide, the v edge applies at that same h edge.
- Between v edges, vpos increments (saturating) on each h edge.
- Visible window:
  - column = hpos - (H_SYNC_PULSE+H_BACK_PORCH) when hpos is in [144, 783].
  - row = vpos - (V_SYNC_PULSE+V_BACK_PORCH) when vpos is in [35, 514].
  - display_enable = both in window AND locked.
- Output timing: row and column are registered and hold their last visible value outside the window. All outputs lag the h_sync pin by 2 clocks (input register + output register).
- Line good: |h_period_meas - H_PERIOD| <= H_TOL.
- Frame good: every line in the frame is good AND v_lines_meas == V_PERIOD. Frame goodness is evaluated when vpos resets.
- Watchdog: if hpos reaches 2*H_PERIOD (no h edge), it counts as a bad line.
- FSM:
  - SEARCH -> VERIFY at the first vpos reset; good-frame count = 0.
  - VERIFY: good frame increments the count; reaching LOCK_FRAMES -> LOCKED, locked <= 1 the same cycle. Bad line or bad frame -> timing_error pulse, count = 0, stay in VERIFY.
  - LOCKED: bad line, bad frame or watchdog -> timing_error pulse, locked <= 0 and display_enable <= 0 on the next clock -> SEARCH.
  - Watchdog in VERIFY -> SEARCH.
- Sync held active for more than one line creates no extra edges; it is caught by the watchdog.
- Reset asserted mid-frame clears everything immediately. After release, lock again requires one partial frame plus LOCK_FRAMES full frames.

Decomposition:
- Package vga_timing_pkg: 640x480 timing constants (shared with the generator), derived H_PERIOD/V_PERIOD and window bounds, and the FSM state encoding (SEARCH, VERIFY, LOCKED).
- Sub-module sync_edge_detect: input register, polarity normalisation and rising-edge pulse. Instantiated twice.

Test Plan:
- Ideal 800x525 stream, H_POL=V_POL=0 -> h_period_meas=800 and v_lines_meas=525. locked=1 at the end of the 3rd v-aligned h edge after the first v edge. No timing_error.
- Locked stream -> display_enable first high with row=0, column=0 exactly 2 clocks after the source's hpos=144 on vpos=35. Last pixel row=479, column=639. 640 enables per visible line, 307200 per frame.
- One line of 801 clocks while locked, H_TOL=0 -> single timing_error pulse, locked=0 next clock, relock after 2 further good frames. Repeat with H_TOL=1 -> no error.
- h_sync stuck inactive while locked -> timing_error exactly when hpos hits 1600, FSM to SEARCH, display_enable=0.
- Frame of 524 lines -> v_lines_meas=524, timing_error, lock dropped.
- reset pulsed mid-frame while locked -> all outputs 0 asynchronously, locked reasserts only after the required frames following release.
